// File: rtl/mac_feeder.sv
// Streams operands A and B from two local buffers to a MAC and collects the result. VALIDs rise 1 cycle after START,
// and WAIT_RES is entered len+1 cycles after START when READY stays high. A and B stall independently on their READYs.
module mac_feeder #(
    parameter int WIDTH_DATA = 32,
    parameter int DEPTH      = 16
) (
    input  logic                       RESET_N,
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic                       WR_EN,
    input  logic                       WR_SEL,
    input  logic [$clog2(DEPTH)-1:0]   WR_ADDR,
    input  logic [WIDTH_DATA-1:0]      WR_DATA,
    input  logic [$clog2(DEPTH):0]     LEN,
    input  logic                       START,
    output logic [WIDTH_DATA-1:0]      A_DATA,
    output logic                       A_VALID,
    output logic                       A_LAST,
    input  logic                       A_READY,
    output logic [WIDTH_DATA-1:0]      B_DATA,
    output logic                       B_VALID,
    output logic                       B_LAST,
    input  logic                       B_READY,
    input  logic [WIDTH_DATA-1:0]      RES_DATA,
    input  logic                       RES_VALID,
    input  logic                       RES_LAST,
    input  logic                       RES_OVERFLOW,
    output logic                       RES_READY,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [WIDTH_DATA-1:0]      RESULT,
    output logic                       RESULT_OVERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
    localparam logic [AW:0] ONE     = 1;

    if (!(WIDTH_DATA == 16 || WIDTH_DATA == 32)) begin : g_bad_width
        $error("mac_feeder: WIDTH_DATA must be 16 or 32");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mac_feeder: DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT_RES
    } state_t;

    state_t                  state_q, state_d;
    logic [AW:0]             len_q, len_d;
    logic [AW:0]             ptr_a_q, ptr_a_d;
    logic [AW:0]             ptr_b_q, ptr_b_d;
    logic [WIDTH_DATA-1:0]   result_q, result_d;
    logic                    ovf_q, ovf_d;
    logic                    done_q, done_d;

    logic [WIDTH_DATA-1:0]   buf_a [DEPTH];
    logic [WIDTH_DATA-1:0]   buf_b [DEPTH];

    logic                    a_vld, b_vld;
    logic                    wr_ok;
    logic [AW:0]             len_clip;

    // Pointers only move on a handshake and buffers are frozen outside IDLE, so VALID/DATA hold while stalled.
    assign a_vld    = (state_q == S_STREAM) && (ptr_a_q < len_q);
    assign b_vld    = (state_q == S_STREAM) && (ptr_b_q < len_q);
    assign wr_ok    = WR_EN && !CLR && (state_q == S_IDLE);
    assign len_clip = (LEN > DEPTH_L) ? DEPTH_L : LEN;

    assign A_VALID         = a_vld;
    assign B_VALID         = b_vld;
    assign A_DATA          = a_vld ? buf_a[ptr_a_q[AW-1:0]] : '0;
    assign B_DATA          = b_vld ? buf_b[ptr_b_q[AW-1:0]] : '0;
    assign A_LAST          = a_vld && (ptr_a_q == len_q - ONE);
    assign B_LAST          = b_vld && (ptr_b_q == len_q - ONE);
    assign RES_READY       = (state_q == S_WAIT_RES);
    assign BUSY            = (state_q != S_IDLE);
    assign DONE            = done_q;
    assign RESULT          = result_q;
    assign RESULT_OVERFLOW = ovf_q;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        ptr_a_d  = ptr_a_q;
        ptr_b_d  = ptr_b_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        if (CLR) begin
            state_d = S_IDLE;
            ptr_a_d = '0;
            ptr_b_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START && (LEN != '0)) begin
                        len_d   = len_clip;
                        ptr_a_d = '0;
                        ptr_b_d = '0;
                        state_d = S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (a_vld && A_READY) begin
                        ptr_a_d = ptr_a_q + ONE;
                    end
                    if (b_vld && B_READY) begin
                        ptr_b_d = ptr_b_q + ONE;
                    end
                    if ((ptr_a_q == len_q) && (ptr_b_q == len_q)) begin
                        state_d = S_WAIT_RES;
                    end
                end
                S_WAIT_RES: begin
                    if (RES_VALID) begin
                        result_d = RES_DATA;
                        ovf_d    = RES_OVERFLOW;
                        if (RES_LAST) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            ptr_a_q  <= '0;
            ptr_b_q  <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            ptr_a_q  <= ptr_a_d;
            ptr_b_q  <= ptr_b_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            if (WR_SEL) begin
                buf_b[WR_ADDR] <= WR_DATA;
            end else begin
                buf_a[WR_ADDR] <= WR_DATA;
            end
        end
    end

endmodule

// File: tb/tb_mac_feeder.sv
// Randomized bench for mac_feeder: per-run expected beat queues built from a shadow buffer image, result/DONE checks.
module tb_mac_feeder;

    localparam int N     = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b1;
    logic          CLR = 1'b0;
    logic          WR_EN = 1'b0;
    logic          WR_SEL = 1'b0;
    logic [AW-1:0] WR_ADDR = '0;
    logic [N-1:0]  WR_DATA = '0;
    logic [AW:0]   LEN = '0;
    logic          START = 1'b0;
    logic [N-1:0]  A_DATA, B_DATA;
    logic          A_VALID, A_LAST, B_VALID, B_LAST;
    logic          A_READY = 1'b0;
    logic          B_READY = 1'b0;
    logic [N-1:0]  RES_DATA = '0;
    logic          RES_VALID = 1'b0;
    logic          RES_LAST = 1'b0;
    logic          RES_OVERFLOW = 1'b0;
    logic          RES_READY, BUSY, DONE, RESULT_OVERFLOW;
    logic [N-1:0]  RESULT;

    mac_feeder #(.WIDTH_DATA(N), .DEPTH(DEPTH)) dut (
        .RESET_N(RESET_N), .CLK(CLK), .CLR(CLR),
        .WR_EN(WR_EN), .WR_SEL(WR_SEL), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .LEN(LEN), .START(START),
        .A_DATA(A_DATA), .A_VALID(A_VALID), .A_LAST(A_LAST), .A_READY(A_READY),
        .B_DATA(B_DATA), .B_VALID(B_VALID), .B_LAST(B_LAST), .B_READY(B_READY),
        .RES_DATA(RES_DATA), .RES_VALID(RES_VALID), .RES_LAST(RES_LAST),
        .RES_OVERFLOW(RES_OVERFLOW), .RES_READY(RES_READY),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .RESULT_OVERFLOW(RESULT_OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int           vectors = 0;
    int           miscompares = 0;
    int           done_cnt = 0;
    logic [N-1:0] ref_a [DEPTH];
    logic [N-1:0] ref_b [DEPTH];
    logic [N:0]   exp_a [$];
    logic [N:0]   exp_b [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beat monitor: handshakes are judged at the negedge before the edge that completes them.
    logic         a_hold = 1'b0, b_hold = 1'b0;
    logic [N-1:0] a_prev, b_prev;
    logic [N:0]   e;
    always @(negedge CLK) begin
        if (!RESET_N) begin
            a_hold = 1'b0;
            b_hold = 1'b0;
        end else begin
            if (DONE) done_cnt++;
            if (a_hold) begin
                check("a_hold_vld", A_VALID, 1);
                check("a_hold_dat", A_DATA, a_prev);
            end
            if (b_hold) begin
                check("b_hold_vld", B_VALID, 1);
                check("b_hold_dat", B_DATA, b_prev);
            end
            if (A_VALID && A_READY && !CLR) begin
                if (exp_a.size() == 0) check("a_extra_beat", exp_a.size(), 1);
                else begin
                    e = exp_a.pop_front();
                    check("a_beat", {A_LAST, A_DATA}, e);
                end
            end
            if (B_VALID && B_READY && !CLR) begin
                if (exp_b.size() == 0) check("b_extra_beat", exp_b.size(), 1);
                else begin
                    e = exp_b.pop_front();
                    check("b_beat", {B_LAST, B_DATA}, e);
                end
            end
            a_hold = A_VALID && !A_READY && !CLR;
            b_hold = B_VALID && !B_READY && !CLR;
            a_prev = A_DATA;
            b_prev = B_DATA;
        end
    end

    function automatic int eff_len(input int n);
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    task automatic wr(input logic sel, input int addr, input logic [N-1:0] d);
        WR_EN = 1'b1; WR_SEL = sel; WR_ADDR = addr[AW-1:0]; WR_DATA = d;
        @(posedge CLK); #1;
        WR_EN = 1'b0;
        if (sel) ref_b[addr] = d;
        else     ref_a[addr] = d;
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            wr(1'b0, i, $urandom);
            wr(1'b1, i, $urandom);
        end
    endtask

    task automatic expect_run(input int n);
        for (int i = 0; i < n; i++) begin
            exp_a.push_back({i == n - 1, ref_a[i]});
            exp_b.push_back({i == n - 1, ref_b[i]});
        end
    endtask

    // Starts a run (len_in >= 1) and returns once WAIT_RES is reached or the cycle budget expires.
    task automatic run_op(input int len_in, input int a_pct, input int b_low);
        int eff, cyc;
        eff = eff_len(len_in);
        expect_run(eff);
        START = 1'b1; LEN = len_in[AW:0];
        @(posedge CLK); #1;
        START = 1'b0;
        check("vld_first", {A_VALID, B_VALID}, 2'b11);
        check("busy_stream", BUSY, 1);
        check("res_rdy_stream", RES_READY, 0);
        cyc = 0;
        A_READY = ($urandom_range(99) < a_pct);
        B_READY = (cyc >= b_low);
        while (!RES_READY && cyc < 300) begin
            @(posedge CLK); #1;
            cyc++;
            A_READY = ($urandom_range(99) < a_pct);
            B_READY = (cyc >= b_low);
        end
        A_READY = 1'b0; B_READY = 1'b0;
        check("wait_res_reached", RES_READY, 1);
        if (a_pct >= 100 && b_low == 0) check("latency", cyc, eff + 1);
        check("a_beats_left", exp_a.size(), 0);
        check("b_beats_left", exp_b.size(), 0);
        check("vld_off_wait", {A_VALID, B_VALID}, 0);
        check("busy_wait", BUSY, 1);
    endtask

    task automatic res_beat(input logic [N-1:0] d, input logic ovf, input logic last);
        int d0;
        d0 = done_cnt;
        RES_VALID = 1'b1; RES_DATA = d; RES_OVERFLOW = ovf; RES_LAST = last;
        @(posedge CLK); #1;
        RES_VALID = 1'b0; RES_LAST = 1'b0;
        check("result", RESULT, d);
        check("result_ovf", RESULT_OVERFLOW, ovf);
        check("done_pulse", DONE, last);
        @(posedge CLK); #1;
        check("done_clear", DONE, 0);
        check("busy_after_res", BUSY, !last);
        check("done_count", done_cnt - d0, last);
    endtask

    initial begin
        int d0;
        logic [N-1:0] r;

        #2 RESET_N = 1'b0;
        #1;
        check("rst_busy", BUSY, 0);
        check("rst_vld", {A_VALID, B_VALID, A_LAST, B_LAST}, 0);
        check("rst_res_rdy", RES_READY, 0);
        check("rst_done", DONE, 0);
        check("rst_result", {RESULT_OVERFLOW, RESULT}, 0);
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;

        for (int i = 0; i < 3; i++) begin
            wr(1'b0, i, 32'h3F80_0000);
            wr(1'b1, i, 32'h4000_0000);
        end
        run_op(3, 100, 0);
        res_beat(32'h40C0_0000, 1'b0, 1'b1);

        fill_random();
        run_op(3, 50, 5);
        res_beat($urandom, 1'b0, 1'b0);
        res_beat($urandom, 1'b1, 1'b1);

        for (int k = 0; k < 4; k++) begin
            fill_random();
            run_op($urandom_range(1, DEPTH + 5), $urandom_range(30, 100), $urandom_range(0, 6));
            res_beat($urandom, 1'($urandom_range(1)), 1'b1);
        end

        run_op(1, 100, 0);
        res_beat($urandom, 1'b0, 1'b1);

        run_op(DEPTH + 5, 100, 0);
        res_beat(32'h7F80_0000, 1'b1, 1'b1);

        START = 1'b1; LEN = '0;
        @(posedge CLK); #1;
        START = 1'b0;
        check("len0_busy", BUSY, 0);
        check("len0_vld", {A_VALID, B_VALID}, 0);
        @(posedge CLK); #1;
        check("len0_busy2", BUSY, 0);

        RES_VALID = 1'b1; RES_DATA = 32'h1234_5678; RES_LAST = 1'b1; RES_OVERFLOW = 1'b0;
        check("idle_res_rdy", RES_READY, 0);
        @(posedge CLK); #1;
        RES_VALID = 1'b0; RES_LAST = 1'b0;
        @(posedge CLK); #1;
        check("idle_res_ignored", {RESULT_OVERFLOW, RESULT}, {1'b1, 32'h7F80_0000});
        check("idle_no_done", DONE, 0);

        d0 = done_cnt;
        r = ref_a[0];
        expect_run(4);
        START = 1'b1; LEN = 5'd4;
        @(posedge CLK); #1;
        START = 1'b0; A_READY = 1'b1; B_READY = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b1; START = 1'b1; LEN = 5'd2;
        WR_EN = 1'b1; WR_SEL = 1'b0; WR_ADDR = '0; WR_DATA = ~r;
        @(posedge CLK); #1;
        CLR = 1'b0; START = 1'b0; WR_EN = 1'b0; A_READY = 1'b0; B_READY = 1'b0;
        check("abort_busy", BUSY, 0);
        check("abort_vld", {A_VALID, B_VALID}, 0);
        check("abort_done", DONE, 0);
        check("abort_a_left", exp_a.size(), 3);
        check("abort_b_left", exp_b.size(), 3);
        exp_a.delete();
        exp_b.delete();
        @(posedge CLK); #1;
        check("abort_start_ignored", BUSY, 0);
        check("abort_result_kept", {RESULT_OVERFLOW, RESULT}, {1'b1, 32'h7F80_0000});
        check("abort_no_done", done_cnt - d0, 0);
        run_op(1, 100, 0);
        res_beat($urandom, 1'b0, 1'b1);

        fill_random();
        run_op(2, 100, 0);
        #1 RESET_N = 1'b0;
        #1;
        check("midrst_busy", BUSY, 0);
        check("midrst_res_rdy", RES_READY, 0);
        check("midrst_vld", {A_VALID, B_VALID, A_LAST, B_LAST}, 0);
        check("midrst_result", {RESULT_OVERFLOW, RESULT, DONE}, 0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        check("midrst_no_done", DONE, 0);
        fill_random();
        run_op(2, 100, 0);
        res_beat($urandom, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
